handshake_rr_arbiter: RTL and testbench
=======================================

Name: handshake_rr_arbiter

Overview:
- Shares one downstream ready/valid channel (5-bit payload) among three upstream ready/valid requesters.
- Uses round-robin arbitration with a configurable burst hold.
- Output goes through a one-entry registered pipeline stage, so the block sits between the three handshake_arr producers and the single handshake consumer of the RTL datapath.
- Per-requester enable masking is supported so software or test logic can fence off a requester.

Parameters:
- WIDTH, 5, payload width of every channel.
- BURST_LEN, 4, maximum consecutive accepted transfers granted to one requester while it keeps valid asserted (1 = pure per-beat round-robin; legal range 1..15).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  synchronous active-high reset.
- en_mask  input  3  bit i = 1 enables requester i; a masked requester is never granted.
- handshake_arr_0_valid / _1_valid / _2_valid  input  1 each  requester valid.
- handshake_arr_0_ready / _1_ready / _2_ready  output  1 each  requester ready.
- in_data_0 / in_data_1 / in_data_2  input  WIDTH each  requester payload.
- handshake_valid  output  1  downstream valid (registered).
- handshake_ready  input  1  downstream ready.
- out_data  output  WIDTH  downstream payload (registered).
- out_id  output  2  index of the requester that produced out_data (registered).
- grant  output  3  one-hot current grant (combinational), 0 when no eligible requester.

Behaviour:
- Clocking and reset: one clock CLK; reset RESET is synchronous and active-high.
- Reset values (synchronous, RESET=1 at a rising edge):
  - handshake_valid=0, out_data=0, out_id=0.
  - rr_ptr=0 (requester 0 highest priority).
  - burst_cnt=0, state=ARB.
  - Reset overrides any in-flight transfer; a held beat is dropped.
- eligible[i] = handshake_arr_i_valid & en_mask[i].
- Stage accept: can_accept = !handshake_valid | handshake_ready.
- State machine:
  - ARB:
    - grant = first eligible requester searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
    - On an accepted beat: if BURST_LEN>1, go to HOLD with owner=winner and burst_cnt=1; otherwise stay in ARB.
  - HOLD:
    - grant = owner if eligible[owner], otherwise fall back to ARB search in the same cycle and leave HOLD.
    - Each accepted beat from owner increments burst_cnt.
    - When burst_cnt reaches BURST_LEN on an accepted beat, return to ARB.
    - Deassertion of owner valid or clearing en_mask[owner] also returns to ARB.
- Readiness: handshake_arr_i_ready = grant[i] & can_accept. At most one ready is high per cycle.
- Transfer: beat accepted from i when handshake_arr_i_valid & handshake_arr_i_ready. At the next edge:
  - handshake_valid=1, out_data=in_data_i, out_id=i.
- rr_ptr update: on the last beat of a grant (ARB with BURST_LEN=1, burst completion, or owner release), rr_ptr = winner+1 mod 3. Otherwise rr_ptr holds.
- Downstream:
  - If handshake_valid & handshake_ready and no new beat is accepted, handshake_valid clears at the next edge.
  - Simultaneous drain and accept reloads the register, sustaining 1 beat/cycle.
  - out_data and out_id are stable while handshake_valid & !handshake_ready.
- Latency: 1 cycle from input acceptance to handshake_valid.
- Upstream contract: no combinational path from handshake_arr_*_valid to handshake_valid. A combinational path from handshake_ready to the arr ready signals is allowed.
- No eligible requesters: grant=0, all arr readies 0, state forced to ARB, rr_ptr unchanged.
- en_mask changes take effect in the same cycle through eligible.
- Protocol assertions the bench checks:
  - No arr valid drops without a handshake (the block must not rely on this).
  - Never more than one arr ready high.
  - handshake_valid stable until ready.

Test Plan:
- Reset, all three valid, en_mask=3'b111, BURST_LEN=1, handshake_ready=1, data 0x01/0x02/0x03 -> out_id sequence 0,1,2,0,... on consecutive cycles starting 1 cycle after the first accept; out_data matches; handshake_valid low in the cycle after reset.
- BURST_LEN=4, requesters 0 and 2 continuously valid -> four beats out_id=0, then four beats out_id=2, then four beats out_id=0; no idle cycles.
- Backpressure: handshake_ready=0 for 3 cycles while requester 1 valid with data 0x1F -> handshake_valid=1, out_data=0x1F, out_id=1 held constant; all arr readies 0; ready=1 then drains exactly one beat and the next beat loads the same cycle.
- Owner release mid-burst (BURST_LEN=4): requester 0 drops valid after 2 beats while 1 is valid -> grant moves to requester 1 the same cycle; rr_ptr becomes 1.
- en_mask=3'b101 with all valid -> requester 1 never granted and handshake_arr_1_ready stays 0; clearing en_mask[0] during a burst by 0 -> immediate switch to requester 2.
- RESET asserted for one cycle while handshake_valid=1 and a burst is in progress -> next cycle handshake_valid=0, grant restarts at requester 0, held beat discarded.

Source files
------------

// File: rtl/handshake_rr_arbiter.sv
// Three-way round-robin arbiter with burst hold, feeding one registered ready/valid output stage.
`timescale 1ns/1ps
module handshake_rr_arbiter #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [2:0]       en_mask,
  input  logic             handshake_arr_0_valid,
  input  logic             handshake_arr_1_valid,
  input  logic             handshake_arr_2_valid,
  output logic             handshake_arr_0_ready,
  output logic             handshake_arr_1_ready,
  output logic             handshake_arr_2_ready,
  input  logic [WIDTH-1:0] in_data_0,
  input  logic [WIDTH-1:0] in_data_1,
  input  logic [WIDTH-1:0] in_data_2,
  output logic             handshake_valid,
  input  logic             handshake_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_id,
  output logic [2:0]       grant
);

  localparam logic [0:0] StArb  = 1'b0;
  localparam logic [0:0] StHold = 1'b1;
  localparam logic [3:0] BurstLenC = 4'(BURST_LEN);
  localparam logic       LongBurst = (BURST_LEN > 1);

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  logic [0:0]       r_state, w_state_d;
  logic [1:0]       r_owner, w_owner_d;
  logic [3:0]       r_burst_cnt, w_burst_cnt_d;
  logic [1:0]       r_rr_ptr, w_rr_ptr_d;
  logic             r_valid, w_valid_d;
  logic [WIDTH-1:0] r_data, w_data_d;
  logic [1:0]       r_id, w_id_d;

  logic [2:0]       w_elig;
  logic [1:0]       w_cand1, w_cand2, w_cand3;
  logic [1:0]       w_winner;
  logic             w_any, w_hold, w_release, w_can_accept, w_accept;
  logic [WIDTH-1:0] w_win_data;

  assign w_elig  = {handshake_arr_2_valid, handshake_arr_1_valid, handshake_arr_0_valid} & en_mask;
  assign w_any   = |w_elig;
  assign w_cand1 = r_rr_ptr;
  assign w_cand2 = inc3(r_rr_ptr);
  assign w_cand3 = inc3(w_cand2);

  // An owner that lost eligibility falls back to the normal search in the same cycle.
  assign w_hold    = (r_state == StHold) && w_elig[r_owner];
  assign w_release = (r_state == StHold) && !w_elig[r_owner];

  always_comb begin
    w_winner = w_cand3;
    if (w_hold) begin
      w_winner = r_owner;
    end else if (w_elig[w_cand1]) begin
      w_winner = w_cand1;
    end else if (w_elig[w_cand2]) begin
      w_winner = w_cand2;
    end
  end

  assign w_can_accept = !r_valid || handshake_ready;
  assign w_accept     = w_any && w_can_accept;
  assign grant        = w_any ? (3'b001 << w_winner) : 3'b000;

  assign handshake_arr_0_ready = grant[0] & w_can_accept;
  assign handshake_arr_1_ready = grant[1] & w_can_accept;
  assign handshake_arr_2_ready = grant[2] & w_can_accept;

  always_comb begin
    w_win_data = in_data_0;
    case (w_winner)
      2'd1:    w_win_data = in_data_1;
      2'd2:    w_win_data = in_data_2;
      default: w_win_data = in_data_0;
    endcase
  end

  always_comb begin
    w_state_d     = r_state;
    w_owner_d     = r_owner;
    w_burst_cnt_d = r_burst_cnt;
    w_rr_ptr_d    = r_rr_ptr;
    if (!w_any) begin
      w_state_d     = StArb;
      w_burst_cnt_d = 4'd0;
    end else if (w_hold) begin
      if (w_accept) begin
        if (r_burst_cnt + 4'd1 == BurstLenC) begin
          w_state_d     = StArb;
          w_burst_cnt_d = 4'd0;
          w_rr_ptr_d    = inc3(r_owner);
        end else begin
          w_burst_cnt_d = r_burst_cnt + 4'd1;
        end
      end
    end else begin
      if (w_release) begin
        w_rr_ptr_d = inc3(r_owner);
      end
      w_state_d     = StArb;
      w_burst_cnt_d = 4'd0;
      if (w_accept) begin
        if (LongBurst) begin
          w_state_d     = StHold;
          w_owner_d     = w_winner;
          w_burst_cnt_d = 4'd1;
        end else begin
          w_rr_ptr_d = inc3(w_winner);
        end
      end
    end
  end

  always_comb begin
    w_valid_d = r_valid;
    w_data_d  = r_data;
    w_id_d    = r_id;
    if (w_accept) begin
      w_valid_d = 1'b1;
      w_data_d  = w_win_data;
      w_id_d    = w_winner;
    end else if (handshake_ready) begin
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= StArb;
      r_owner     <= 2'd0;
      r_burst_cnt <= 4'd0;
      r_rr_ptr    <= 2'd0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_id        <= 2'd0;
    end else begin
      r_state     <= w_state_d;
      r_owner     <= w_owner_d;
      r_burst_cnt <= w_burst_cnt_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_valid     <= w_valid_d;
      r_data      <= w_data_d;
      r_id        <= w_id_d;
    end
  end

  assign handshake_valid = r_valid;
  assign out_data        = r_data;
  assign out_id          = r_id;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Bench for handshake_rr_arbiter: one instance per burst length, shared stimulus, scoreboarded output.
`timescale 1ns/1ps
module tb_handshake_rr_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET;
  logic [2:0] en_mask;
  logic       v0, v1, v2;
  logic [4:0] d0, d1, d2;
  logic       hs_ready;

  logic       a_r0, a_r1, a_r2, a_valid;
  logic [4:0] a_data;
  logic [1:0] a_id;
  logic [2:0] a_grant;
  logic       b_r0, b_r1, b_r2, b_valid;
  logic [4:0] b_data;
  logic [1:0] b_id;
  logic [2:0] b_grant;
  wire  [2:0] a_rdy = {a_r2, a_r1, a_r0};
  wire  [2:0] b_rdy = {b_r2, b_r1, b_r0};

  handshake_rr_arbiter #(.WIDTH(5), .BURST_LEN(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .en_mask(en_mask),
    .handshake_arr_0_valid(v0), .handshake_arr_1_valid(v1), .handshake_arr_2_valid(v2),
    .handshake_arr_0_ready(a_r0), .handshake_arr_1_ready(a_r1), .handshake_arr_2_ready(a_r2),
    .in_data_0(d0), .in_data_1(d1), .in_data_2(d2),
    .handshake_valid(a_valid), .handshake_ready(hs_ready),
    .out_data(a_data), .out_id(a_id), .grant(a_grant)
  );

  handshake_rr_arbiter #(.WIDTH(5), .BURST_LEN(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .en_mask(en_mask),
    .handshake_arr_0_valid(v0), .handshake_arr_1_valid(v1), .handshake_arr_2_valid(v2),
    .handshake_arr_0_ready(b_r0), .handshake_arr_1_ready(b_r1), .handshake_arr_2_ready(b_r2),
    .in_data_0(d0), .in_data_1(d1), .in_data_2(d2),
    .handshake_valid(b_valid), .handshake_ready(hs_ready),
    .out_data(b_data), .out_id(b_id), .grant(b_grant)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [1:0] id;
    logic [4:0] data;
  } beat_t;
  beat_t q[$];

  typedef struct {
    logic [2:0] mask;
    logic [2:0] vld;
    logic [2:0] gnt;
  } vec_t;
  vec_t tbl[9];

  logic sel = 1'b0;  // 0 selects the BURST_LEN=1 instance for the scoreboard
  logic idle_chk = 1'b0;
  logic chk_no1 = 1'b0;
  int   n_pop = 0;
  int   pop_base = 0;

  wire       sel_valid = sel ? b_valid : a_valid;
  wire [4:0] sel_data  = sel ? b_data : a_data;
  wire [1:0] sel_id    = sel ? b_id : a_id;

  logic       pa_v = 1'b0, pb_v = 1'b0, p_rdy = 1'b0, p_rst = 1'b1;
  logic [4:0] pa_d, pb_d;
  logic [1:0] pa_id, pb_id;

  always @(negedge CLK) begin
    beat_t e;
    if (idle_chk && (n_pop > pop_base) && q.size() != 0) chk("no_idle", sel_valid, 1);
    if (chk_no1) begin
      chk("masked_r1_b1", a_r1, 0);
      chk("masked_r1_b4", b_r1, 0);
    end
    if (sel_valid && hs_ready && q.size() != 0) begin
      e = q.pop_front();
      n_pop++;
      chk("sb_id", sel_id, e.id);
      chk("sb_data", sel_data, e.data);
    end
    chk("onehot_ready_b1", int'($countones(a_rdy) <= 1), 1);
    chk("onehot_ready_b4", int'($countones(b_rdy) <= 1), 1);
    if (!p_rst && !p_rdy) begin
      if (pa_v) begin
        chk("hold_valid_b1", a_valid, 1);
        chk("hold_data_b1", a_data, pa_d);
        chk("hold_id_b1", a_id, pa_id);
      end
      if (pb_v) begin
        chk("hold_valid_b4", b_valid, 1);
        chk("hold_data_b4", b_data, pb_d);
        chk("hold_id_b4", b_id, pb_id);
      end
    end
    pa_v = a_valid; pa_d = a_data; pa_id = a_id;
    pb_v = b_valid; pb_d = b_data; pb_id = b_id;
    p_rdy = hs_ready; p_rst = RESET;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    {v2, v1, v0} = 3'b000;
    step();
    RESET = 1'b0;
  endtask

  task automatic push(input logic [1:0] id, input logic [4:0] data);
    beat_t e;
    e.id = id;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic start_seq();
    q.delete();
    pop_base = n_pop;
  endtask

  task automatic wait_sb(input int budget);
    int i = 0;
    while (q.size() != 0 && i < budget) begin
      step();
      i++;
    end
    if (q.size() != 0) begin
      chk("sb_timeout_left", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    RESET = 1'b1; en_mask = 3'b111; {v2, v1, v0} = 3'b000;
    d0 = 5'h00; d1 = 5'h00; d2 = 5'h00; hs_ready = 1'b1;
    step();

    // Grant decode straight out of reset (rr_ptr = 0, ARB, empty stage).
    tbl[0] = '{3'b111, 3'b111, 3'b001};
    tbl[1] = '{3'b111, 3'b110, 3'b010};
    tbl[2] = '{3'b111, 3'b100, 3'b100};
    tbl[3] = '{3'b111, 3'b000, 3'b000};
    tbl[4] = '{3'b101, 3'b010, 3'b000};
    tbl[5] = '{3'b110, 3'b011, 3'b010};
    tbl[6] = '{3'b011, 3'b100, 3'b000};
    tbl[7] = '{3'b000, 3'b111, 3'b000};
    tbl[8] = '{3'b100, 3'b111, 3'b100};
    for (int i = 0; i < 9; i++) begin
      do_reset();
      en_mask = tbl[i].mask;
      {v2, v1, v0} = tbl[i].vld;
      #1;
      chk("tbl_grant_b1", a_grant, tbl[i].gnt);
      chk("tbl_ready_b1", a_rdy, tbl[i].gnt);
      chk("tbl_grant_b4", b_grant, tbl[i].gnt);
      chk("tbl_valid_after_reset", a_valid, 0);
    end

    // Pure per-beat round robin.
    do_reset();
    sel = 1'b0; en_mask = 3'b111; hs_ready = 1'b1;
    d0 = 5'h01; d1 = 5'h02; d2 = 5'h03;
    start_seq();
    for (int r = 0; r < 2; r++) begin
      push(2'd0, 5'h01); push(2'd1, 5'h02); push(2'd2, 5'h03);
    end
    idle_chk = 1'b1;
    {v2, v1, v0} = 3'b111;
    wait_sb(20);
    idle_chk = 1'b0;

    // Bursts of four alternating between requesters 0 and 2.
    do_reset();
    sel = 1'b1; d0 = 5'h0A; d2 = 5'h0C;
    start_seq();
    for (int k = 0; k < 4; k++) push(2'd0, 5'h0A);
    for (int k = 0; k < 4; k++) push(2'd2, 5'h0C);
    for (int k = 0; k < 4; k++) push(2'd0, 5'h0A);
    idle_chk = 1'b1;
    {v2, v1, v0} = 3'b101;
    wait_sb(30);
    idle_chk = 1'b0;

    // Backpressure with a held beat, then drain-and-reload in one cycle.
    do_reset();
    sel = 1'b0; hs_ready = 1'b0; d1 = 5'h1F; v1 = 1'b1;
    step();
    d1 = 5'h15;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("bp_valid", a_valid, 1);
      chk("bp_data", a_data, 5'h1F);
      chk("bp_id", a_id, 1);
      chk("bp_readies", a_rdy, 3'b000);
    end
    step();
    hs_ready = 1'b1;
    #1;
    chk("bp_ready1_on_drain", a_r1, 1);
    step();
    v1 = 1'b0;
    @(negedge CLK);
    chk("bp_reload_valid", a_valid, 1);
    chk("bp_reload_data", a_data, 5'h15);
    step();
    #1;
    chk("bp_drained", a_valid, 0);

    // Owner release after two beats; the pointer must have moved to 1.
    do_reset();
    sel = 1'b1; d0 = 5'h04; d1 = 5'h11;
    start_seq();
    push(2'd0, 5'h04); push(2'd0, 5'h04); push(2'd1, 5'h11);
    {v2, v1, v0} = 3'b011;
    step();
    step();
    v0 = 1'b0;
    #1;
    chk("rel_grant", b_grant, 3'b010);
    chk("rel_ready1", b_r1, 1);
    step();
    v1 = 1'b0;
    step();
    {v2, v1, v0} = 3'b111;
    #1;
    chk("rel_rrptr_is_1", b_grant, 3'b010);
    wait_sb(10);

    // Masked requester 1 never served.
    do_reset();
    en_mask = 3'b101; d0 = 5'h06; d1 = 5'h07; d2 = 5'h08;
    start_seq();
    for (int k = 0; k < 4; k++) push(2'd0, 5'h06);
    for (int k = 0; k < 4; k++) push(2'd2, 5'h08);
    for (int k = 0; k < 4; k++) push(2'd0, 5'h06);
    idle_chk = 1'b1; chk_no1 = 1'b1;
    {v2, v1, v0} = 3'b111;
    wait_sb(30);
    idle_chk = 1'b0; chk_no1 = 1'b0;

    // Clearing en_mask[0] mid-burst switches straight to requester 2.
    do_reset();
    en_mask = 3'b101;
    start_seq();
    push(2'd0, 5'h06); push(2'd0, 5'h06); push(2'd2, 5'h08); push(2'd2, 5'h08);
    {v2, v1, v0} = 3'b111;
    step();
    step();
    en_mask = 3'b100;
    #1;
    chk("mask_switch_grant", b_grant, 3'b100);
    chk("mask_switch_ready0", b_r0, 0);
    chk("mask_switch_ready2", b_r2, 1);
    wait_sb(10);

    // Reset mid-burst with a beat held downstream.
    do_reset();
    en_mask = 3'b111; hs_ready = 1'b1; d0 = 5'h09; d2 = 5'h1B;
    v2 = 1'b1;
    step();
    step();
    {v2, v1, v0} = 3'b111;
    hs_ready = 1'b0;
    RESET = 1'b1;
    #1;
    chk("rst_burst_grant", b_grant, 3'b100);
    chk("rst_held_valid", b_valid, 1);
    step();
    RESET = 1'b0;
    #1;
    chk("rst_valid", b_valid, 0);
    chk("rst_data", b_data, 0);
    chk("rst_id", b_id, 0);
    chk("rst_grant", b_grant, 3'b001);
    step();
    chk("rst_first_valid", b_valid, 1);
    chk("rst_first_id", b_id, 0);
    chk("rst_first_data", b_data, 5'h09);

    {v2, v1, v0} = 3'b000;
    hs_ready = 1'b1;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
